// File: rtl/nanorv32_irq_arb.sv
// nanorv32_irq_arb -- interrupt arbiter for the nanorv32 core.
//
// Collects NUM_IRQ interrupt sources. Each source is either edge or level
// type. The lowest eligible index wins. The request is raised to the
// pipeline flow controller and held through an ack/RETI handshake.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   irq_src[NUM_IRQ]     interrupt sources (synchronous to clk)
//   irq                  request to the flow controller (high only in REQ)
//   irq_ack              core entered the IRQ micro-code sequence (pulse)
//   reti                 core finished the RETI micro-code sequence (pulse)
//   irq_id[3]            index of the source being requested / serviced
//   cfg_we/addr/wdata    register write port (0 ENABLE, 1 EDGE, 2 PENDING W1C, 3 STATUS)
//   cfg_rdata[8]         read data, combinational from cfg_addr

// Per-source front end: input register, edge detect and edge pending bit.
module nanorv32_irq_src (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic edge_mode,
  input  logic clr,
  output logic src_q,
  output logic pend
);

  logic pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      src_q <= src;
      // The edge pending bit is kept at 0 while the source is level type,
      // so that switching to edge mode never exposes a stale request.
      // A new edge beats a clear that lands in the same cycle.
      if (!edge_mode)          pend_q <= 1'b0;
      else if (src && !src_q)  pend_q <= 1'b1;
      else if (clr)            pend_q <= 1'b0;
    end
  end

  // A level source is pending exactly while its registered input is high.
  assign pend = edge_mode ? pend_q : src_q;

endmodule

module nanorv32_irq_arb #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic               irq,
  input  logic               irq_ack,
  input  logic               reti,
  output logic [2:0]         irq_id,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [7:0]         cfg_wdata,
  output logic [7:0]         cfg_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         id_q, id_d;
  logic [NUM_IRQ-1:0] enable_q, edge_q;
  logic [NUM_IRQ-1:0] src_q, pend, clr, elig;
  logic [2:0]         win_id;
  logic               w1c, ack_ok;

  assign w1c    = cfg_we && (cfg_addr == 2'd2);
  assign ack_ok = (state_q == REQ) && irq_ack;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src
    // Software W1C, or the ack of the source currently latched in irq_id.
    assign clr[i] = (w1c && cfg_wdata[i]) || (ack_ok && (id_q == 3'(i)));

    nanorv32_irq_src u_src (
      .clk       (clk),
      .rst_n     (rst_n),
      .src       (irq_src[i]),
      .edge_mode (edge_q[i]),
      .clr       (clr[i]),
      .src_q     (src_q[i]),
      .pend      (pend[i])
    );
  end

  // Config registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q <= '0;
      edge_q   <= '0;
    end else if (cfg_we) begin
      if (cfg_addr == 2'd0) enable_q <= cfg_wdata[NUM_IRQ-1:0];
      if (cfg_addr == 2'd1) edge_q   <= cfg_wdata[NUM_IRQ-1:0];
    end
  end

  assign elig = pend & enable_q;

  // Lowest index wins: scan from the top down so the last hit is the lowest.
  always_comb begin
    win_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (elig[i]) win_id = 3'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  // irq_id is latched only on IDLE->REQ and then held through REQ and
  // SERVICE; a source that goes away in REQ is left for software to sort
  // out through STATUS.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: if (|elig) begin
        state_d = REQ;
        id_d    = win_id;
      end
      REQ:     if (irq_ack) state_d = SERVICE;
      SERVICE: if (reti)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign irq    = (state_q == REQ);
  assign irq_id = id_q;

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0: cfg_rdata = 8'(enable_q);
      2'd1: cfg_rdata = 8'(edge_q);
      2'd2: cfg_rdata = 8'(pend);
      2'd3: cfg_rdata = {state_q == SERVICE, state_q == REQ, 3'b000, id_q};
      default: cfg_rdata = '0;
    endcase
  end

endmodule

// File: doc/nanorv32_irq_arb.md
NANORV32_IRQ_ARB -- requirements
Module: nanorv32_irq_arb

Interface
REQ-001 The block SHALL have parameter NUM_IRQ, default 8, meaning the number of interrupt sources (2..8).
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port irq_src, input, NUM_IRQ bits: interrupt sources, synchronous to clk.
REQ-005 The block SHALL have port irq, output, 1 bit: interrupt request to the pipeline flow controller.
REQ-006 The block SHALL have port irq_ack, input, 1 bit: single-cycle pulse from the core when it enters the IRQ micro-code sequence.
REQ-007 The block SHALL have port reti, input, 1 bit: single-cycle pulse from the core when the RETI micro-code sequence completes.
REQ-008 The block SHALL have port irq_id, output, 3 bits: index of the source being requested or serviced.
REQ-009 The block SHALL have port cfg_we, input, 1 bit: config register write strobe.
REQ-010 The block SHALL have port cfg_addr, input, 2 bits: register select (0 ENABLE, 1 EDGE, 2 PENDING, 3 STATUS).
REQ-011 The block SHALL have port cfg_wdata, input, 8 bits: write data.
REQ-012 The block SHALL have port cfg_rdata, output, 8 bits: read data, combinational from cfg_addr.

Function
REQ-013 The block SHALL register irq_src into src_r every cycle.
REQ-014 Source i SHALL be edge type when EDGE[i]=1 and level type when EDGE[i]=0.
REQ-015 For an edge source, PENDING[i] SHALL set on the clock where irq_src[i]=1 and src_r[i]=0.
REQ-016 For a level source, PENDING[i] SHALL equal src_r[i] and SHALL ignore writes.
REQ-017 A write of 1 to bit i of PENDING SHALL clear PENDING[i] of an edge source; writing 0 SHALL have no effect.
REQ-018 When an edge set and a clear (software or ack) hit the same bit in the same cycle, the set SHALL win.
REQ-019 The eligible vector SHALL be PENDING & ENABLE; the lowest index SHALL have the highest priority.
REQ-020 The FSM SHALL have three states: IDLE, REQ and SERVICE; irq SHALL be 1 only in REQ.
REQ-021 IDLE -> REQ SHALL occur when eligible is non-zero; on that edge the winning index SHALL be latched into irq_id.
REQ-022 irq_id SHALL hold in REQ even if a higher-priority source becomes eligible or the latched source is withdrawn; software resolves spurious entry via STATUS.
REQ-023 REQ -> SERVICE SHALL occur on irq_ack=1, and PENDING[irq_id] SHALL clear on that edge if the source is edge type.
REQ-024 SERVICE -> IDLE SHALL occur on reti=1; there is no nesting, and irq SHALL stay 0 throughout SERVICE.
REQ-025 After reti, a still-eligible source SHALL re-raise irq no earlier than 2 cycles after the reti pulse (IDLE for at least one cycle).
REQ-026 irq_ack outside REQ and reti outside SERVICE SHALL be ignored with no state change.
REQ-027 STATUS read SHALL return {state==SERVICE, state==REQ, 3'b0, irq_id}; writes to STATUS SHALL be ignored.
REQ-028 ENABLE and EDGE SHALL be read/write; bits at or above NUM_IRQ SHALL read 0.
REQ-029 Clearing ENABLE[irq_id] while in REQ or SERVICE SHALL NOT abort the FSM.
REQ-030 Edge latency: a rising edge sampled at clock N SHALL set PENDING at N and assert irq at N+1 from IDLE.

Reset
REQ-031 On rst_n=0, asynchronously: state=IDLE, irq=0, irq_id=0, ENABLE=0, EDGE=0, edge PENDING=0, src_r=0.
REQ-032 A reset asserted in REQ or SERVICE SHALL drop irq immediately; the first post-reset request SHALL need a fresh eligible source.

Verification
REQ-033 ENABLE=0xFF, EDGE=0x01; pulse irq_src[0] for 1 cycle -> PENDING=0x01, irq=1 the next cycle, irq_id=0; ack -> PENDING=0x00, STATUS=0x80.
REQ-034 Levels on sources 5 and 2 asserted together -> irq_id=2; ack, then reti while source 2 is still high -> irq re-raised 2 cycles later with irq_id=2.
REQ-035 In REQ with irq_id=4, raise source 1 -> irq_id stays 4 until ack; after reti -> next request has irq_id=1.
REQ-036 Edge on source 3 in the same cycle as a W1C write of 0x08 -> PENDING[3] remains 1.
REQ-037 reti pulse in IDLE and irq_ack pulse in SERVICE -> no state change, STATUS unchanged.
REQ-038 rst_n low for 1 cycle while in SERVICE -> irq=0, STATUS=0x00, all registers at reset values.
